data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001: Parameter DEPTH_WORDS, default 256, number of 32-bit words stored; power of two, at least 4.
REQ-002: Parameter WAIT_CYCLES, default 1, wait states inserted before each response; range 0..15.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005: req_valid  input  1  initiator presents a request.
REQ-006: req_ready  output  1  responder can accept a request.
REQ-007: req_we  input  1  1 = store, 0 = load.
REQ-008: req_funct3  input  3  RV32 width code; loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-009: req_addr  input  32  byte address.
REQ-010: req_wdata  input  32  store data; low bits used for SB/SH.
REQ-011: rsp_valid  output  1  one-cycle response pulse.
REQ-012: rsp_rdata  output  32  load result, extended per funct3; held until next response.
REQ-013: rsp_err  output  1  request rejected; qualified by rsp_valid.

Function
REQ-014: FSM states are IDLE, WAIT and RESP.
REQ-015: req_ready SHALL be 1 only in IDLE.
REQ-016: Handshake: a request is accepted on the rising edge where req_valid=1 and req_ready=1; all req_* fields are captured at that edge.
REQ-017: Only one request is outstanding at a time; req_* changes after acceptance have no effect.
REQ-018: IDLE on accept: go to RESP with error flagged if the request is erroneous, else go to WAIT with counter=WAIT_CYCLES.
REQ-019: When WAIT_CYCLES=0, an accepted legal request goes to WAIT and completes on the next edge.
REQ-020: WAIT: decrement the counter each cycle; at counter=0, perform the access and go to RESP.
REQ-021: RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
REQ-022: Latency: legal request accepted at edge k gives rsp_valid high during cycle k+WAIT_CYCLES+1; erroneous request gives rsp_valid high during cycle k+1.
REQ-023: Back-to-back throughput: a new request can be accepted on the edge ending RESP+1, i.e., no more than one request per WAIT_CYCLES+3 cycles.
REQ-024: Errors are flagged as rsp_err=1 with rsp_rdata=0 and no memory change.
REQ-025: Error condition 1, illegal funct3: loads 011/110/111; stores with funct3 not in {000,001,010}.
REQ-026: Error condition 2, misaligned: half access with addr[0]=1; word access with addr[1:0]!=00.
REQ-027: Error condition 3, out of range: addr >= 4*DEPTH_WORDS.
REQ-028: Word index is addr[log2(DEPTH_WORDS)+1:2]; byte lane is addr[1:0]; little-endian.
REQ-029: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all four lanes; untouched lanes are preserved.
REQ-030: LB/LH sign-extend the selected byte/half to 32 bits; LBU/LHU zero-extend it.
REQ-031: A successful store returns rsp_err=0 and rsp_rdata=0.
REQ-032: A load following a store to the same address returns the stored data.

Reset
REQ-033: While rst=0: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-034: req_ready rises in the first cycle after rst is released.
REQ-035: Memory array contents are not reset and are undefined until written.
REQ-036: Reset asserted during WAIT abandons the pending access: no write is committed and no rsp_valid is produced.

Verification
REQ-037: Scenario: WAIT_CYCLES=1; SW addr 0x10, data 0xDEADBEEF; then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
REQ-038: Scenario: after the above, SB 0x11 with data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-039: Scenario: LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD; LH 0x13 -> rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after accept.
REQ-040: Scenario: SW 0x400 with DEPTH_WORDS=256 -> rsp_err=1; store with funct3=011 -> rsp_err=1; memory at 0x0 unchanged on readback.
REQ-041: Scenario: WAIT_CYCLES=3; assert rst=0 two cycles after SW 0x20 of 0x12345678 is accepted -> no rsp_valid; after reset, SW 0x20 of 0 then LW 0x20 -> 0x00000000.
REQ-042: Scenario: hold req_valid=1 continuously with WAIT_CYCLES=0 -> req_ready low in WAIT and RESP; accepts exactly one request every 3 cycles; rsp_valid never high for 2 consecutive cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Single-outstanding RV32 data-memory responder. Accepts one
//               load/store request per handshake, waits WAIT_CYCLES wait
//               states, performs the access on a byte-addressed, little-
//               endian word array and returns a one-cycle response pulse.
//               Illegal width codes, misaligned and out-of-range requests
//               are rejected with rsp_err=1, rsp_rdata=0 and no memory
//               change.
// Ports       : clk        - clock, rising edge active
//               rst        - asynchronous reset, active low
//               req_valid  - request present
//               req_ready  - responder idle and able to accept
//               req_we     - 1 = store, 0 = load
//               req_funct3 - RV32 width code
//               req_addr   - byte address
//               req_wdata  - store data (low bits used for SB/SH)
//               rsp_valid  - one-cycle response pulse
//               rsp_rdata  - extended load result, held between responses
//               rsp_err    - request rejected (qualified by rsp_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_idx_w     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nx;
    logic                r_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rdata;
    logic [31:0]         w_rdata_nx;
    logic                r_err;
    logic                w_err_nx;

    // Request fields captured at the accepting edge
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [c_idx_w+1:0]  r_addr;
    logic [31:0]         r_wdata;
    logic                r_err_pend;

    logic                w_accept;
    logic                w_mem_we;
    logic                w_f3_ok;
    logic                w_misalign;
    logic                w_oob;
    logic                w_req_err;

    logic [31:0]         r_mem [DEPTH_WORDS];
    logic [c_idx_w-1:0]  w_idx;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
    logic [3:0]          w_be;
    logic [31:0]         w_wlane;

    // ------------------------------------------------------------------
    // Request legality, evaluated on the live request fields
    // ------------------------------------------------------------------
    always_comb begin
        w_f3_ok = 1'b0;
        if (req_we) begin
            w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                      (req_funct3 == 3'b010);
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end
        // funct3[1:0] encodes the access size for every legal code
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_oob      = (req_addr >> (c_idx_w + 2)) != 32'd0;
        w_req_err  = !w_f3_ok || w_misalign || w_oob;
    end

    // ------------------------------------------------------------------
    // Datapath: load extraction and store lane steering
    // ------------------------------------------------------------------
    assign w_idx  = r_addr[c_idx_w+1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rdata_nx = r_rdata;
        w_err_nx   = r_err;
        w_accept   = 1'b0;
        w_mem_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_ready) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_WAIT;
                    // Rejected requests make a single zero-count pass
                    // through WAIT, so their response arrives one cycle
                    // after acceptance; no access is made on that pass.
                    w_cnt_nx   = w_req_err ? 4'd0 : c_wait_init;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nx = S_RESP;
                    w_err_nx   = r_err_pend;
                    w_rdata_nx = 32'd0;
                    if (!r_err_pend) begin
                        if (r_we) begin
                            w_mem_we = 1'b1;
                        end else begin
                            w_rdata_nx = w_load;
                        end
                    end
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register. Ready and response flags are registered from the
    // next state so they stay low throughout reset and ready rises on
    // the first edge after release.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_err_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_ready     <= (w_state_nx == S_IDLE);
            r_rsp_valid <= (w_state_nx == S_RESP);
            r_rdata     <= w_rdata_nx;
            r_err       <= w_err_nx;
            if (w_accept) begin
                r_we       <= req_we;
                r_funct3   <= req_funct3;
                r_addr     <= req_addr[c_idx_w+1:0];
                r_wdata    <= req_wdata;
                r_err_pend <= w_req_err;
            end
        end
    end

    // Storage array is intentionally not reset. A reset asserted during
    // WAIT forces the state to IDLE, which removes the write strobe.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed bench for data_mem_responder. Three instances share
//               clock, reset and request fields, each with its own
//               req_valid: WAIT_CYCLES=1, 3 and 0 respectively.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic [2:0]  vld;
    logic [2:0]  rdy;
    logic [2:0]  rvld;
    logic [2:0]  rerr;
    logic [31:0] rdat [3];
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rvld[0]), .rsp_rdata(rdat[0]),
        .rsp_err(rerr[0])
    );
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rvld[1]), .rsp_rdata(rdat[1]),
        .rsp_err(rerr[1])
    );
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rvld[2]), .rsp_rdata(rdat[2]),
        .rsp_err(rerr[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One complete transaction on instance d with expected response,
    // latency (edges from accept to the response edge), one-cycle pulse
    // and rdata hold checks.
    task automatic run(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_er,
                       input int exp_lat, input string tag);
        int          t;
        int          lat;
        logic [31:0] rd;
        logic        er;
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        vld[d]     = 1'b1;
        t = 0;
        while (!rdy[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_ready"}, {31'd0, rdy[d]}, 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; it must have no effect
        vld[d]     = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = ~wd;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (rvld[d]) break;
        end
        rd = rdat[d];
        er = rerr[d];
        chk({tag, "_lat"},   lat, exp_lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"},   {31'd0, er}, {31'd0, exp_er});
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, rvld[d]}, 32'd0);
        chk({tag, "_hold"},  rdat[d], rd);
    endtask

    initial begin
        int hits;
        int acc;
        rst        = 1'b0;
        vld        = 3'b000;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;

        // Reset state
        #12;
        chk("rst_ready", {29'd0, rdy}, 32'd0);
        chk("rst_valid", {29'd0, rvld}, 32'd0);
        chk("rst_err",   {29'd0, rerr}, 32'd0);
        chk("rst_rdata", rdat[0], 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_ready_low", {29'd0, rdy}, 32'd0);
        @(negedge clk);
        chk("rel_ready_high", {29'd0, rdy}, 32'd7);

        // WAIT_CYCLES=1 instance
        run(0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, "sw10");
        run(0, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, "lw10");
        run(0, 1'b1, 3'b000, 32'h11,  32'hAAAAAA80, 32'h0,        1'b0, 2, "sb11");
        run(0, 1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0, 2, "lb11");
        run(0, 1'b0, 3'b100, 32'h11,  32'h0,        32'h00000080, 1'b0, 2, "lbu11");
        run(0, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0, 2, "lw10b");
        run(0, 1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0, 2, "lh12");
        run(0, 1'b0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 1'b0, 2, "lhu12");
        run(0, 1'b0, 3'b001, 32'h13,  32'h0,        32'h0,        1'b1, 1, "lh13");
        run(0, 1'b1, 3'b010, 32'h0,   32'h11223344, 32'h0,        1'b0, 2, "sw0");
        run(0, 1'b1, 3'b010, 32'h400, 32'hFFFFFFFF, 32'h0,        1'b1, 1, "sw400");
        run(0, 1'b1, 3'b011, 32'h0,   32'hFFFFFFFF, 32'h0,        1'b1, 1, "s011");
        run(0, 1'b0, 3'b010, 32'h0,   32'h0,        32'h11223344, 1'b0, 2, "lw0");
        run(0, 1'b1, 3'b001, 32'h2,   32'h7777BEEF, 32'h0,        1'b0, 2, "sh2");
        run(0, 1'b0, 3'b010, 32'h0,   32'h0,        32'hBEEF3344, 1'b0, 2, "lw0b");
        run(0, 1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0, 2, "sw3fc");
        run(0, 1'b0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, 2, "lw3fc");
        run(0, 1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        1'b1, 1, "l011");
        run(0, 1'b0, 3'b010, 32'h6,   32'h0,        32'h0,        1'b1, 1, "lw6");

        // WAIT_CYCLES=3 instance: reset abandons a pending store
        run(1, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, 32'h0,        1'b0, 4, "w3_sw20");
        run(1, 1'b0, 3'b010, 32'h20, 32'h0,        32'hA5A5A5A5, 1'b0, 4, "w3_lw20");
        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        vld[1]     = 1'b1;
        chk("w3_ab_ready", {31'd0, rdy[1]}, 32'd1);
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        hits = 0;
        @(posedge clk);
        #1;
        if (rvld[1]) hits++;
        @(posedge clk);
        #1;
        if (rvld[1]) hits++;
        rst = 1'b0;
        #1;
        chk("w3_ab_rst_ready", {31'd0, rdy[1]}, 32'd0);
        chk("w3_ab_rst_valid", {31'd0, rvld[1]}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rvld[1]) hits++;
        end
        chk("w3_ab_no_rsp", hits, 32'd0);
        run(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0, 4, "w3_lw20_kept");
        run(1, 1'b1, 3'b010, 32'h20, 32'h0, 32'h0,        1'b0, 4, "w3_sw20z");
        run(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0,        1'b0, 4, "w3_lw20z");

        // WAIT_CYCLES=0 instance: req_valid held high continuously
        @(negedge clk);
        chk("w0_ready", {31'd0, rdy[2]}, 32'd1);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h4;
        req_wdata  = 32'h55;
        vld[2]     = 1'b1;
        acc = 0;
        for (int j = 1; j <= 9; j++) begin
            chk($sformatf("w0_rdy_e%0d", j), {31'd0, rdy[2]}, {31'd0, (j % 3) == 1});
            if (rdy[2]) acc++;
            @(posedge clk);
            #1;
            chk($sformatf("w0_vld_e%0d", j), {31'd0, rvld[2]}, {31'd0, (j % 3) == 2});
            @(negedge clk);
        end
        vld[2] = 1'b0;
        chk("w0_accepts", acc, 32'd3);
        run(2, 1'b0, 3'b010, 32'h4,   32'h0, 32'h00000055, 1'b0, 1, "w0_lw4");
        run(2, 1'b0, 3'b000, 32'h400, 32'h0, 32'h0,        1'b1, 1, "w0_oob");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
